sha1_feeder: RTL and testbench

SHA1_FEEDER -- requirements
Module: sha1_feeder

---
 rtl/sha1_feeder.sv | 110 +++++++++++
 tb/tb_sha1_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_feeder.sv
// Buffers big-endian message words in a 32-entry FIFO and sequences them into a SHA-1 round pipeline.
// Optional SHA1_FEEDER_BYTESWAP_EN byte-reverses each word as it is written into the FIFO.
module sha1_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Din,
  output logic        load,
  output logic        phase_advance,
  output logic [6:0]  round,
  output logic        busy,
  output logic        block_done,
  output logic [1:0]  dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the registered FIFO count.

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem [32];
  logic [4:0]  wr_ptr, rd_ptr;
  logic [5:0]  count;
  logic [5:0]  count_avail;
  logic [6:0]  round_d;
  logic [31:0] wr_word;
  logic        push, pop;
  logic        busy_d, phase_d, done_d;

  assign in_ready    = (count < 6'd32);
  assign push        = in_valid && in_ready;
  assign count_avail = count + {5'd0, push};
  assign dbg_state   = state_q;

`ifdef SHA1_FEEDER_BYTESWAP_EN
  assign wr_word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign wr_word = in_data;
`endif

  always_comb begin
    state_d = state_q;
    round_d = 7'd0;
    case (state_q)
      S_IDLE: begin
        if (count >= 6'd16) state_d = S_LOAD;
      end
      S_LOAD: begin
        round_d = round + 7'd1;
        if (round == 7'd15) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        if (round == 7'd79) begin
          // A word arriving on round 79 can complete the next block with no bubble.
          if (count_avail >= 6'd16) state_d = S_LOAD;
          else                      state_d = S_FLUSH;
        end else begin
          round_d = round + 7'd1;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = (state_d == S_LOAD);
    busy_d  = (state_d == S_LOAD) || (state_d == S_EXPAND);
    done_d  = (state_d == S_EXPAND) && (round_d == 7'd79);
    phase_d = ((state_d == S_LOAD) && (round_d == 7'd0)) ||
              ((state_d == S_EXPAND) &&
               ((round_d == 7'd20) || (round_d == 7'd40) || (round_d == 7'd60))) ||
              (state_d == S_FLUSH);
  end

  // Outputs are registered from the next state so Din/load/phase_advance share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      round         <= 7'd0;
      load          <= 1'b0;
      Din           <= 32'd0;
      busy          <= 1'b0;
      phase_advance <= 1'b0;
      block_done    <= 1'b0;
      wr_ptr        <= 5'd0;
      rd_ptr        <= 5'd0;
      count         <= 6'd0;
    end else begin
      state_q       <= state_d;
      round         <= round_d;
      load          <= pop;
      Din           <= pop ? mem[rd_ptr] : 32'd0;
      busy          <= busy_d;
      phase_advance <= phase_d;
      block_done    <= done_d;
      if (push) wr_ptr <= wr_ptr + 5'd1;
      if (pop)  rd_ptr <= rd_ptr + 5'd1;
      count         <= count + {5'd0, push} - {5'd0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: tb/tb_sha1_feeder.sv
// Self-checking bench for sha1_feeder: block-position reference model, per-cycle compare, directed and random traffic.
// Honours SHA1_FEEDER_BYTESWAP_EN when the design is built with it.
module tb_sha1_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Din;
  logic        load, phase_advance, busy, block_done;
  logic [6:0]  round;
  logic [1:0]  dbg_state;

  sha1_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .Din(Din), .load(load), .phase_advance(phase_advance), .round(round), .busy(busy),
    .block_done(block_done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] swap_in(input logic [31:0] d);
`ifdef SHA1_FEEDER_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // ---------------- reference model ----------------
  // m_pos: -1 idle, 0..79 position within a block, 80 the single flush cycle.
  logic [31:0] exp_q[$];
  int          m_pos = -1;
  logic [31:0] e_din = 32'd0;
  logic        e_load = 1'b0, e_busy = 1'b0, e_phase = 1'b0, e_done = 1'b0;
  logic [6:0]  e_round = 7'd0;

  initial begin
    bit m_push, start;
    int nxt;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_pos = -1;
        e_din = 32'd0;
      end else begin
        m_push = in_valid && (exp_q.size() < 32);
        if (m_pos == -1) start = (exp_q.size() >= 16);
        else             start = (exp_q.size() + (m_push ? 1 : 0)) >= 16;
        if (m_pos == -1)      nxt = start ? 0 : -1;
        else if (m_pos == 79) nxt = start ? 0 : 80;
        else if (m_pos == 80) nxt = -1;
        else                  nxt = m_pos + 1;
        e_din = 32'd0;
        if (nxt >= 0 && nxt <= 15) e_din = exp_q.pop_front();
        if (m_push) exp_q.push_back(swap_in(in_data));
        m_pos = nxt;
      end
      e_load  = (m_pos >= 0 && m_pos <= 15);
      e_busy  = (m_pos >= 0 && m_pos <= 79);
      e_round = e_busy ? 7'(m_pos) : 7'd0;
      e_phase = (m_pos == 0) || (m_pos == 20) || (m_pos == 40) || (m_pos == 60) || (m_pos == 80);
      e_done  = (m_pos == 79);
    end
  end

  // ---------------- compare + event log ----------------
  logic [31:0] din_log[$];
  int          ph_log[$];
  int          flush_cnt = 0, done_cnt = 0, b2b_cnt = 0, prev_round = 0;
  bit          saw_full = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("din", Din, e_din);
      check("load", load, e_load);
      check("round", round, e_round);
      check("busy", busy, e_busy);
      check("phase_advance", phase_advance, e_phase);
      check("block_done", block_done, e_done);
      check("in_ready", in_ready, exp_q.size() < 32);
      if (load) din_log.push_back(Din);
      if (phase_advance && busy) ph_log.push_back(int'(round));
      if (phase_advance && !busy) flush_cnt++;
      if (block_done) done_cnt++;
      if (load && round == 7'd0 && prev_round == 79) b2b_cnt++;
      if (!in_ready) saw_full = 1'b1;
      prev_round = int'(round);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    din_log.delete();
    ph_log.delete();
    flush_cnt = 0;
    done_cnt  = 0;
    b2b_cnt   = 0;
    saw_full  = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 2000) begin
      step();
      g++;
    end
    check("push_wait_bound", g < 2000, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(m_pos == -1 && exp_q.size() < 16) && g < 5000) begin
      step();
      g++;
    end
    check("idle_wait_bound", g < 5000, 1'b1);
    repeat (3) step();
  endtask

  task automatic wait_round(input int r);
    int g = 0;
    while (int'(round) != r && g < 300) begin
      step();
      g++;
    end
    check("round_wait_bound", g < 300, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single block 1..16 back-to-back.
    clear_logs();
    for (int i = 1; i <= 16; i++) push_word(32'(i));
    wait_idle();
    check("t1_load_words", din_log.size(), 16);
    for (int i = 0; i < 16 && i < din_log.size(); i++) check("t1_din", din_log[i], 32'(swap_in(32'(i + 1))));
    check("t1_phase_cnt", ph_log.size(), 4);
    for (int i = 0; i < 4 && i < ph_log.size(); i++) check("t1_phase_round", ph_log[i], 20 * i);
    check("t1_block_done", done_cnt, 1);
    check("t1_flush", flush_cnt, 1);
    check("t1_busy_end", busy, 1'b0);

    // 48 words: FIFO fills, then back-to-back blocks with a single final flush.
    clear_logs();
    for (int i = 0; i < 48; i++) push_word(32'h100 + 32'(i));
    wait_idle();
    check("t2_saw_full", saw_full, 1'b1);
    check("t2_b2b", b2b_cnt, 2);
    check("t2_done", done_cnt, 3);
    check("t2_flush", flush_cnt, 1);
    check("t2_words", din_log.size(), 48);
    for (int i = 0; i < 48 && i < din_log.size(); i++) check("t2_din", din_log[i], swap_in(32'h100 + 32'(i)));

    // 15 words never start a block; the 16th starts it within two cycles.
    clear_logs();
    for (int i = 0; i < 15; i++) push_word($urandom);
    repeat (100) step();
    check("t3_idle_busy", busy, 1'b0);
    check("t3_idle_load", din_log.size(), 0);
    push_word($urandom);
    k = 0;
    while (!load && k < 4) begin
      step();
      k++;
    end
    check("t3_start_latency", k <= 2, 1'b1);
    wait_idle();

    // Reset at round 40 with ten more words queued.
    clear_logs();
    for (int i = 0; i < 26; i++) push_word($urandom);
    wait_round(40);
    rst_n = 1'b0;
    #1;
    check("t4_rst_din", Din, 32'd0);
    check("t4_rst_load", load, 1'b0);
    check("t4_rst_round", round, 7'd0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_phase", phase_advance, 1'b0);
    check("t4_rst_done", block_done, 1'b0);
    step();
    rst_n = 1'b1;
    check("t4_ready", in_ready, 1'b1);
    repeat (30) step();
    check("t4_no_flush", flush_cnt, 0);
    check("t4_still_idle", busy, 1'b0);

    // Byte order of the first word.
    clear_logs();
    push_word(32'h61626380);
    for (int i = 0; i < 15; i++) push_word($urandom);
    wait_idle();
`ifdef SHA1_FEEDER_BYTESWAP_EN
    check("t5_swap", din_log.size() > 0 ? din_log[0] : 32'hx, 32'h80636261);
`else
    check("t5_swap", din_log.size() > 0 ? din_log[0] : 32'hx, 32'h61626380);
`endif

    // Next block completed by a word pushed on round 79.
    clear_logs();
    for (int i = 0; i < 31; i++) push_word($urandom);
    wait_round(79);
    push_word($urandom);
    wait_idle();
    check("t6_b2b", b2b_cnt, 1);
    check("t6_flush", flush_cnt, 1);
    check("t6_done", done_cnt, 2);

    // Random bursts and gaps.
    for (int b = 0; b < 20; b++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        push_word($urandom);
        repeat ($urandom_range(0, 3)) step();
      end
      repeat ($urandom_range(0, 150)) step();
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
